// File: rtl/ibex_dummy_instr_checker.sv
// Tracks IF dummy tags from ID accept to WB retire, keeps dummies out of minstret and flags tag/encoding/FIFO inconsistencies.
// Latency: count enable combinational; dummy counter and alerts one cycle. Never backpressures. Optional gap check: IBEX_DUMMY_GAP_CHECK_EN.
module ibex_dummy_instr_checker #(
    parameter int unsigned TrackDepth = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dummy_instr_en_i,
    input  logic [2:0]  dummy_instr_mask_i,
    input  logic        instr_valid_id_i,
    input  logic        instr_id_done_i,
    input  logic        instr_is_dummy_id_i,
    input  logic [31:0] instr_rdata_id_i,
    input  logic        instr_retire_i,
    input  logic        flush_i,
    output logic        retire_count_en_o,
    output logic [31:0] dummy_retired_cnt_o,
    output logic        integrity_alert_o,
    output logic        integrity_err_o
);
    localparam int unsigned PtrW = $clog2(TrackDepth);
    localparam logic [PtrW:0] Depth = (PtrW+1)'(TrackDepth);

    logic [TrackDepth-1:0] tag_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW:0]         occ_q;
    logic [31:0]           dummy_cnt_q;
    logic                  alert_q;
    logic                  err_q;

    logic accept, empty, full, head_tag;
    logic push, pop, underflow, overflow;
    logic enc_valid, enc_err, gap_err, err_any;

    assign accept = instr_valid_id_i & instr_id_done_i & ~flush_i;
    assign empty  = (occ_q == '0);
    assign full   = (occ_q == Depth);

    assign head_tag  = ~empty & tag_q[rd_ptr_q];
    assign pop       = instr_retire_i & ~empty;
    assign underflow = instr_retire_i & empty;
    // A same-cycle retire frees the slot, so only a retire-less accept on a full FIFO overflows.
    assign overflow  = accept & full & ~instr_retire_i;
    assign push      = accept & ~overflow;

    // Only the four R-type ops the inserter can emit, always with rd = x0.
    always_comb begin
        enc_valid = 1'b0;
        if (instr_rdata_id_i[6:0] == 7'b0110011 && instr_rdata_id_i[11:7] == 5'd0) begin
            case ({instr_rdata_id_i[31:25], instr_rdata_id_i[14:12]})
                10'b0000000_000,
                10'b0000000_111,
                10'b0000001_000,
                10'b0000001_100: enc_valid = 1'b1;
                default:         enc_valid = 1'b0;
            endcase
        end
    end

    assign enc_err = accept & instr_is_dummy_id_i & (~enc_valid | ~dummy_instr_en_i);

    assign retire_count_en_o   = instr_retire_i & ~head_tag;
    assign dummy_retired_cnt_o = dummy_cnt_q;
    assign integrity_alert_o   = alert_q;
    assign integrity_err_o     = err_q;

`ifdef IBEX_DUMMY_GAP_CHECK_EN
    logic [5:0] gap_q;
    logic [5:0] gap_limit;

    assign gap_limit = 6'({dummy_instr_mask_i, 2'b11}) + 6'd1;
    // Fires on the accept that pushes the count past the limit; the count then holds until cleared.
    assign gap_err   = dummy_instr_en_i & accept & ~instr_is_dummy_id_i & (gap_q == gap_limit);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gap_q <= '0;
        end else if (!dummy_instr_en_i || flush_i || (accept && instr_is_dummy_id_i)) begin
            gap_q <= '0;
        end else if (accept && gap_q <= gap_limit) begin
            gap_q <= gap_q + 6'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^instr_rdata_id_i[24:15];
`else
    assign gap_err = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{instr_rdata_id_i[24:15], dummy_instr_mask_i};
`endif

    assign err_any = enc_err | underflow | overflow | gap_err;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tag_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= '0;
            dummy_cnt_q <= '0;
            alert_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= instr_is_dummy_id_i;
            end
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PtrW'(1);
                end
                if (push && !pop) begin
                    occ_q <= occ_q + (PtrW+1)'(1);
                end else if (pop && !push) begin
                    occ_q <= occ_q - (PtrW+1)'(1);
                end
            end
            if (pop && head_tag) begin
                dummy_cnt_q <= dummy_cnt_q + 32'd1;
            end
            alert_q <= err_any;
            err_q   <= err_q | err_any;
        end
    end
endmodule

// File: tb/tb_ibex_dummy_instr_checker.sv
// Directed bench for ibex_dummy_instr_checker; each task drives one scenario and checks inline against hand-derived values.
module tb_ibex_dummy_instr_checker;
    logic        clk_i;
    logic        rst_ni;
    logic        dummy_instr_en_i;
    logic [2:0]  dummy_instr_mask_i;
    logic        instr_valid_id_i;
    logic        instr_id_done_i;
    logic        instr_is_dummy_id_i;
    logic [31:0] instr_rdata_id_i;
    logic        instr_retire_i;
    logic        flush_i;
    logic        retire_count_en_o;
    logic [31:0] dummy_retired_cnt_o;
    logic        integrity_alert_o;
    logic        integrity_err_o;

    int vectors;
    int miscompares;

    ibex_dummy_instr_checker #(.TrackDepth(2)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .dummy_instr_en_i    (dummy_instr_en_i),
        .dummy_instr_mask_i  (dummy_instr_mask_i),
        .instr_valid_id_i    (instr_valid_id_i),
        .instr_id_done_i     (instr_id_done_i),
        .instr_is_dummy_id_i (instr_is_dummy_id_i),
        .instr_rdata_id_i    (instr_rdata_id_i),
        .instr_retire_i      (instr_retire_i),
        .flush_i             (flush_i),
        .retire_count_en_o   (retire_count_en_o),
        .dummy_retired_cnt_o (dummy_retired_cnt_o),
        .integrity_alert_o   (integrity_alert_o),
        .integrity_err_o     (integrity_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    localparam int NENC = 11;
    logic [31:0] enc_word  [NENC] = '{32'h0000_0033, 32'h0062_F033, 32'h02A5_8033, 32'h0200_4033,
                                      32'h0200_5033, 32'h4000_0033, 32'h0000_00B3, 32'h0000_0013,
                                      32'h0000_0033, 32'h0000_00B3, 32'h0000_0033};
    logic        enc_en    [NENC] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        enc_tag   [NENC] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        enc_alert [NENC] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic acc, input logic tag, input logic [31:0] word,
                         input logic ret, input logic fl);
        instr_valid_id_i    = acc;
        instr_id_done_i     = acc;
        instr_is_dummy_id_i = tag;
        instr_rdata_id_i    = word;
        instr_retire_i      = ret;
        flush_i             = fl;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        vectors++; if (retire_count_en_o !== 1'b0) begin miscompares++; $display("FAIL reset_rce: got %b want 0", retire_count_en_o); end
        vectors++; if (dummy_retired_cnt_o !== 32'h0) begin miscompares++; $display("FAIL reset_cnt: got %h want 0", dummy_retired_cnt_o); end
        vectors++; if (integrity_alert_o !== 1'b0) begin miscompares++; $display("FAIL reset_alert: got %b want 0", integrity_alert_o); end
        vectors++; if (integrity_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", integrity_err_o); end
        rst_ni = 1'b1;
    endtask

    task automatic test_dummy_retire();
        do_reset();
        drive(1'b1, 1'b1, 32'h0000_0033, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        vectors++; if (retire_count_en_o !== 1'b0) begin miscompares++; $display("FAIL dummy_rce: got %b want 0", retire_count_en_o); end
        vectors++; if (dummy_retired_cnt_o !== 32'd0) begin miscompares++; $display("FAIL dummy_cnt_before: got %0d want 0", dummy_retired_cnt_o); end
        vectors++; if (integrity_alert_o !== 1'b0) begin miscompares++; $display("FAIL dummy_accept_alert: got %b want 0", integrity_alert_o); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (dummy_retired_cnt_o !== 32'd1) begin miscompares++; $display("FAIL dummy_cnt_after: got %0d want 1", dummy_retired_cnt_o); end
        vectors++; if (integrity_alert_o !== 1'b0) begin miscompares++; $display("FAIL dummy_retire_alert: got %b want 0", integrity_alert_o); end
        vectors++; if (integrity_err_o !== 1'b0) begin miscompares++; $display("FAIL dummy_err: got %b want 0", integrity_err_o); end
    endtask

    task automatic test_encoding();
        for (int i = 0; i < NENC; i++) begin
            do_reset();
            dummy_instr_en_i = enc_en[i];
            drive(1'b1, enc_tag[i], enc_word[i], 1'b0, 1'b0);
            tick();
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            vectors++;
            if (integrity_alert_o !== enc_alert[i]) begin
                miscompares++;
                $display("FAIL enc[%0d] word=%h en=%b tag=%b: alert got %b want %b",
                         i, enc_word[i], enc_en[i], enc_tag[i], integrity_alert_o, enc_alert[i]);
            end
        end
        dummy_instr_en_i = 1'b1;
    endtask

    task automatic test_bad_tag_sticky();
        do_reset();
        drive(1'b1, 1'b1, 32'h0000_00B3, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (integrity_alert_o !== 1'b1) begin miscompares++; $display("FAIL badtag_alert: got %b want 1", integrity_alert_o); end
        vectors++; if (integrity_err_o !== 1'b1) begin miscompares++; $display("FAIL badtag_err: got %b want 1", integrity_err_o); end
        tick();
        vectors++; if (integrity_alert_o !== 1'b0) begin miscompares++; $display("FAIL badtag_alert_pulse: got %b want 0", integrity_alert_o); end
        repeat (3) tick();
        vectors++; if (integrity_err_o !== 1'b1) begin miscompares++; $display("FAIL badtag_err_sticky: got %b want 1", integrity_err_o); end
        rst_ni = 1'b0;
        tick();
        vectors++; if (integrity_err_o !== 1'b0) begin miscompares++; $display("FAIL badtag_err_reset: got %b want 0", integrity_err_o); end
        rst_ni = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 1'b0, 32'h0000_0013, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 1'b0, 32'h0000_0013, 1'b1, 1'b0);
        #1;
        vectors++; if (retire_count_en_o !== 1'b1) begin miscompares++; $display("FAIL b2b_rce: got %b want 1", retire_count_en_o); end
        tick();
        drive(1'b1, 1'b0, 32'h0000_0013, 1'b0, 1'b0);
        vectors++; if (integrity_alert_o !== 1'b0) begin miscompares++; $display("FAIL b2b_full_accept_retire: got %b want 0", integrity_alert_o); end
        tick();
        vectors++; if (integrity_alert_o !== 1'b1) begin miscompares++; $display("FAIL b2b_overflow1: got %b want 1", integrity_alert_o); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (integrity_alert_o !== 1'b1) begin miscompares++; $display("FAIL b2b_overflow2: got %b want 1", integrity_alert_o); end
        tick();
        vectors++; if (integrity_alert_o !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_alert: got %b want 0", integrity_alert_o); end
        vectors++; if (integrity_err_o !== 1'b1) begin miscompares++; $display("FAIL b2b_err: got %b want 1", integrity_err_o); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 1'b0, 32'h0000_0013, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h0000_0033, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h0000_0033, 1'b1, 1'b1);
        #1;
        vectors++; if (retire_count_en_o !== 1'b1) begin miscompares++; $display("FAIL flush_rce: got %b want 1", retire_count_en_o); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        vectors++; if (retire_count_en_o !== 1'b1) begin miscompares++; $display("FAIL underflow_rce: got %b want 1", retire_count_en_o); end
        vectors++; if (integrity_alert_o !== 1'b0) begin miscompares++; $display("FAIL flush_alert: got %b want 0", integrity_alert_o); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (integrity_alert_o !== 1'b1) begin miscompares++; $display("FAIL underflow_alert: got %b want 1", integrity_alert_o); end
        vectors++; if (dummy_retired_cnt_o !== 32'd0) begin miscompares++; $display("FAIL flush_cnt: got %0d want 0", dummy_retired_cnt_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, 1'b1, 32'h0000_0033, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        force dut.dummy_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.dummy_cnt_q;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        vectors++; if (retire_count_en_o !== 1'b0) begin miscompares++; $display("FAIL wrap_rce: got %b want 0", retire_count_en_o); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (dummy_retired_cnt_o !== 32'h0) begin miscompares++; $display("FAIL wrap_cnt: got %h want 00000000", dummy_retired_cnt_o); end
        vectors++; if (integrity_alert_o !== 1'b0) begin miscompares++; $display("FAIL wrap_alert: got %b want 0", integrity_alert_o); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1'b1, 1'b1, 32'h0000_0033, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h0000_00B3, 1'b0, 1'b0);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (integrity_alert_o !== 1'b0) begin miscompares++; $display("FAIL midrst_alert: got %b want 0", integrity_alert_o); end
        vectors++; if (integrity_err_o !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b want 0", integrity_err_o); end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        vectors++; if (retire_count_en_o !== 1'b1) begin miscompares++; $display("FAIL midrst_empty_rce: got %b want 1", retire_count_en_o); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (integrity_alert_o !== 1'b1) begin miscompares++; $display("FAIL midrst_underflow: got %b want 1", integrity_alert_o); end
    endtask

    task automatic test_gap();
        logic exp;
        do_reset();
        dummy_instr_mask_i = 3'b000;
        for (int i = 1; i <= 7; i++) begin
            drive(1'b1, 1'b0, 32'h0000_0013, (i > 1), 1'b0);
            tick();
`ifdef IBEX_DUMMY_GAP_CHECK_EN
            exp = (i == 5);
`else
            exp = 1'b0;
`endif
            vectors++;
            if (integrity_alert_o !== exp) begin
                miscompares++;
                $display("FAIL gap_accept%0d: alert got %b want %b", i, integrity_alert_o, exp);
            end
        end
        drive(1'b1, 1'b1, 32'h0000_0033, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (integrity_alert_o !== 1'b0) begin miscompares++; $display("FAIL gap_clear: got %b want 0", integrity_alert_o); end
        dummy_instr_mask_i = 3'b111;
    endtask

    initial begin
        vectors            = 0;
        miscompares        = 0;
        rst_ni             = 1'b0;
        dummy_instr_en_i   = 1'b1;
        dummy_instr_mask_i = 3'b111;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        test_reset();
        test_dummy_retire();
        test_encoding();
        test_bad_tag_sticky();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_mid_reset();
        test_gap();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
